// File: rtl/sprite_shifter.sv
// sprite_shifter
// Serialises a WIDTH-bit sprite graphic one pixel at a time after a
// horizontal strobe. Supports per-pixel stretch (1x/2x/4x/8x), reflection,
// 1-4 repeated copies separated by a programmable blank gap, and a
// vertical-delay pair of graphics registers.
//
// Ports:
//   clk        pixel-domain clock
//   reset_n    asynchronous active-low reset
//   pixel_en   pixel-advance enable (counters move only when 1)
//   data       graphic written by load
//   load       write pulse: gfx_new <= data, gfx_old <= gfx_new
//   vdelay     1 = draw from gfx_old, 0 = draw from gfx_new
//   stretch    enabled cycles per bit: 0->1, 1->2, 2->4, 3->8
//   reflect    0 = MSB first, 1 = LSB first
//   copies     number of copies minus one
//   gap        enabled blank cycles between copies
//   strobe     start drawing at copy 0, bit 0
//   value      current pixel
//   busy       high while drawing or waiting in a gap
//   copy_index copy currently drawn or awaited
module sprite_shifter #(
  parameter int WIDTH    = 8,
  parameter int GAP_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pixel_en,
  input  logic [WIDTH-1:0]    data,
  input  logic                load,
  input  logic                vdelay,
  input  logic [1:0]          stretch,
  input  logic                reflect,
  input  logic [1:0]          copies,
  input  logic [GAP_BITS-1:0] gap,
  input  logic                strobe,
  output logic                value,
  output logic                busy,
  output logic [1:0]          copy_index
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    gfx_new_q, gfx_new_d;
  logic [WIDTH-1:0]    gfx_old_q, gfx_old_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [2:0]          str_q, str_d;
  logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]          copy_q, copy_d;

  logic [WIDTH-1:0]    sel_gfx;
  logic [2:0]          str_lim;
  logic [BW-1:0]       pix_idx;

  // Graphics register writes and the graphic a new copy would capture.
  // Selection uses the post-load values so a load coinciding with a
  // strobe is seen by the new run.
  always_comb begin
    gfx_new_d = gfx_new_q;
    gfx_old_d = gfx_old_q;
    if (load) begin
      gfx_new_d = data;
      gfx_old_d = gfx_new_q;
    end else begin
      gfx_new_d = gfx_new_q;
      gfx_old_d = gfx_old_q;
    end
    sel_gfx = vdelay ? gfx_old_d : gfx_new_d;
  end

  // Last stretch count value for the live stretch setting.
  always_comb begin
    case (stretch)
      2'd0:    str_lim = 3'd0;
      2'd1:    str_lim = 3'd1;
      2'd2:    str_lim = 3'd3;
      2'd3:    str_lim = 3'd7;
      default: str_lim = 3'd0;
    endcase
  end

  // Sequencer: strobe restarts from any state, otherwise counters advance
  // on enabled pixel cycles through draw and gap phases.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    bit_d     = bit_q;
    str_d     = str_q;
    gap_cnt_d = gap_cnt_q;
    copy_d    = copy_q;
    if (strobe) begin
      state_d   = ST_DRAW;
      bit_d     = '0;
      str_d     = 3'd0;
      copy_d    = 2'd0;
      pattern_d = sel_gfx;
    end else begin
      case (state_q)
        ST_DRAW: begin
          if (pixel_en) begin
            // >= keeps a shrinking stretch setting from running the
            // counter all the way round before the bit advances.
            if (str_q >= str_lim) begin
              str_d = 3'd0;
              if (bit_q == LAST_BIT) begin
                if (copy_q == copies) begin
                  state_d = ST_IDLE;
                  bit_d   = '0;
                end else if (gap == '0) begin
                  bit_d     = '0;
                  copy_d    = copy_q + 2'd1;
                  pattern_d = sel_gfx;
                end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap;
                end
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end else begin
              str_d = str_q + 3'd1;
            end
          end else begin
            state_d = ST_DRAW;
          end
        end
        ST_GAP: begin
          if (pixel_en) begin
            // Leaving on a count of 1 makes the gap last exactly gap cycles.
            if (gap_cnt_q <= GAP_BITS'(1)) begin
              state_d   = ST_DRAW;
              gap_cnt_d = '0;
              bit_d     = '0;
              str_d     = 3'd0;
              copy_d    = copy_q + 2'd1;
              pattern_d = sel_gfx;
            end else begin
              gap_cnt_d = gap_cnt_q - GAP_BITS'(1);
            end
          end else begin
            state_d = ST_GAP;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gfx_new_q <= '0;
      gfx_old_q <= '0;
      pattern_q <= '0;
      bit_q     <= '0;
      str_q     <= 3'd0;
      gap_cnt_q <= '0;
      copy_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      gfx_new_q <= gfx_new_d;
      gfx_old_q <= gfx_old_d;
      pattern_q <= pattern_d;
      bit_q     <= bit_d;
      str_q     <= str_d;
      gap_cnt_q <= gap_cnt_d;
      copy_q    <= copy_d;
    end
  end

  // Reflect is applied live so a change shows on the very next pixel.
  assign pix_idx    = reflect ? bit_q : (LAST_BIT - bit_q);
  assign value      = (state_q == ST_DRAW) ? pattern_q[pix_idx] : 1'b0;
  assign busy       = (state_q != ST_IDLE);
  assign copy_index = copy_q;

endmodule

// File: tb/tb_sprite_shifter.sv
module tb_sprite_shifter;

  localparam int W = 8;
  localparam int GB = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pixel_en = 1'b1;
  logic [W-1:0]  data = '0;
  logic          load = 1'b0;
  logic          vdelay = 1'b0;
  logic [1:0]    stretch = 2'd0;
  logic          reflect = 1'b0;
  logic [1:0]    copies = 2'd0;
  logic [GB-1:0] gap = '0;
  logic          strobe = 1'b0;
  logic          value;
  logic          busy;
  logic [1:0]    copy_index;

  sprite_shifter #(.WIDTH(W), .GAP_BITS(GB)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en), .data(data),
    .load(load), .vdelay(vdelay), .stretch(stretch), .reflect(reflect),
    .copies(copies), .gap(gap), .strobe(strobe), .value(value),
    .busy(busy), .copy_index(copy_index)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_mode = 0;      // 0: always enabled, 1: toggle, 2: random
  bit mon_en = 1'b0;

  // Expected {value, copy_index} per enabled pixel period.
  logic [2:0] exp_q[$];

  // Reference graphics registers.
  logic [W-1:0] m_new = '0;
  logic [W-1:0] m_old = '0;

  // pixel_en driver: changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0: pixel_en = 1'b1;
        1: pixel_en = ~pixel_en;
        default: pixel_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare the visible pixel against the scoreboard head; the
  // head is retired only when the upcoming edge is an enabled one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_extra: busy=1 with no pixel expected at %0t", $time);
        end else begin
          if ({value, copy_index} !== exp_q[0]) begin
            errors++;
            $display("FAIL pixel: got value=%0b copy_index=%0d, expected value=%0b copy_index=%0d at %0t",
                     value, copy_index, exp_q[0][2], exp_q[0][1:0], $time);
          end
          if (pixel_en) void'(exp_q.pop_front());
        end
      end else begin
        checks++;
        if (value !== 1'b0) begin
          errors++;
          $display("FAIL idle_value: got %0b expected 0 at %0t", value, $time);
        end
      end
    end
  end

  // Reference: expand one strobe into its pixel sequence.
  task automatic push_seq(input logic [W-1:0] g, input int s, input bit r,
                          input int c, input int gp);
    for (int k = 0; k <= c; k++) begin
      for (int b = 0; b < W; b++) begin
        for (int t = 0; t < (1 << s); t++) begin
          exp_q.push_back({(r ? g[b] : g[W-1-b]), 2'(k)});
        end
      end
      if (k < c) begin
        for (int t = 0; t < gp; t++) exp_q.push_back({1'b0, 2'(k)});
      end
    end
  endtask

  task automatic cfg(input int s, input bit r, input int c, input int gp, input bit vd);
    stretch = 2'(s);
    reflect = r;
    copies  = 2'(c);
    gap     = GB'(gp);
    vdelay  = vd;
  endtask

  task automatic do_load(input logic [W-1:0] d);
    @(posedge clk); #1;
    data = d;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    m_old = m_new;
    m_new = d;
  endtask

  task automatic do_strobe(input bit with_load, input logic [W-1:0] d);
    logic [W-1:0] sel;
    @(posedge clk); #1;
    strobe = 1'b1;
    if (with_load) begin
      data = d;
      load = 1'b1;
    end
    @(posedge clk); #1;
    strobe = 1'b0;
    load = 1'b0;
    if (with_load) begin
      m_old = m_new;
      m_new = d;
    end
    sel = vdelay ? m_old : m_new;
    exp_q.delete();
    push_seq(sel, int'(stretch), reflect, int'(copies), int'(gap));
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk); #2;
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: busy still 1 after 5000 cycles", name);
    end else if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_length: busy fell with %0d pixels still expected", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic run(input string name, input logic [W-1:0] d, input int s, input bit r,
                     input int c, input int gp);
    do_load(d);
    cfg(s, r, c, gp, 1'b0);
    do_strobe(1'b0, d);
    wait_idle(name);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (value !== 1'b0 || busy !== 1'b0 || copy_index !== 2'd0) begin
      errors++;
      $display("FAIL %s: got value=%0b busy=%0b copy_index=%0d, expected all 0",
               name, value, busy, copy_index);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset");
    mon_en = 1'b1;

    // Directed cases.
    run("a5_basic",    8'hA5, 0, 1'b0, 0, 0);
    run("80_str2",     8'h80, 2, 1'b0, 0, 0);
    run("80_str3",     8'h80, 3, 1'b0, 0, 0);
    run("01_norefl",   8'h01, 0, 1'b0, 0, 0);
    run("01_refl",     8'h01, 0, 1'b1, 0, 0);
    run("ff_gap4",     8'hFF, 0, 1'b0, 1, 4);
    run("ff_gap0",     8'hFF, 0, 1'b0, 1, 0);
    run("c3_4copies",  8'hC3, 1, 1'b1, 3, 7);

    // Vertical delay: two loads, draw from old then from new.
    do_load(8'h0F);
    do_load(8'hF0);
    cfg(0, 1'b0, 0, 0, 1'b1);
    do_strobe(1'b0, '0);
    wait_idle("vdelay1");
    cfg(0, 1'b0, 0, 0, 1'b0);
    do_strobe(1'b0, '0);
    wait_idle("vdelay0");

    // Load coinciding with strobe, both vdelay settings.
    cfg(0, 1'b0, 0, 0, 1'b0);
    do_strobe(1'b1, 8'h3C);
    wait_idle("ldstb_vd0");
    cfg(0, 1'b1, 0, 0, 1'b1);
    do_strobe(1'b1, 8'h96);
    wait_idle("ldstb_vd1");

    // Restart mid-draw at pixel 3.
    do_load(8'hA5);
    cfg(0, 1'b0, 1, 3, 1'b0);
    do_strobe(1'b0, '0);
    repeat (2) @(posedge clk);
    do_strobe(1'b0, '0);
    wait_idle("restart");

    // Pixel enable toggling: every pixel held for two clocks.
    en_mode = 1;
    run("toggle_en", 8'hA5, 0, 1'b0, 1, 2);
    en_mode = 0;

    // Asynchronous reset mid-draw.
    do_load(8'hFF);
    cfg(1, 1'b0, 2, 3, 1'b0);
    do_strobe(1'b0, '0);
    repeat (20) @(posedge clk);
    #2;
    reset_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    m_new = '0;
    m_old = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Randomised runs.
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      en_mode = $urandom_range(0, 2);
      cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        do_strobe(1'b1, d);
      end else begin
        do_load(d);
        do_strobe(1'b0, d);
      end
      wait_idle("random");
    end
    en_mode = 0;

    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
